fir_out_fifo: RTL and testbench
===============================

FIR_OUT_FIFO -- requirements
Module: fir_out_fifo

Interface
REQ-001 Parameter SHIFT, default 15, arithmetic right-shift applied to the 32-bit accumulator (Q15 coefficient scaling).
REQ-002 Parameter DEPTH, default 16, number of FIFO entries; must be a power of two, from 2 to 64.
REQ-003 Parameter N_OUT, default 10063, number of output samples in one complete filter run.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rstn  in  1  asynchronous active-low reset.
REQ-006 din  in  32  signed accumulator value from the filter FSM (its dout).
REQ-007 valid_in  in  1  filter result-valid level; may stay high for more than one cycle.
REQ-008 clr  in  1  synchronous clear of FIFO, counters and flags.
REQ-009 out_data  out  16  signed rounded and saturated sample at the FIFO head.
REQ-010 out_valid  out  1  FIFO is non-empty.
REQ-011 out_ready  in  1  consumer accepts out_data.
REQ-012 sample_cnt  out  14  number of samples accepted into the FIFO.
REQ-013 done  out  1  sample_cnt has reached N_OUT.
REQ-014 overflow  out  1  sticky flag: at least one sample was dropped because the FIFO was full.
REQ-015 sat  out  1  sticky flag: at least one sample was clipped by saturation.

Function
REQ-016 Capture: register valid_d <= valid_in; capture event = valid_in & ~valid_d; exactly one capture per valid_in high period.
REQ-017 Round: add 2^(SHIFT-1) to sign-extended din in 33 bits, then arithmetic-shift right by SHIFT; when SHIFT = 0, pass din through unchanged.
REQ-018 Saturate: clip the shifted value to [-32768, 32767]; any clip sets sat.
REQ-019 Latency: capture sampled at edge k -> entry written at edge k -> out_valid high after edge k when the FIFO was empty.
REQ-020 FIFO: write pointer, read pointer and count 0..DEPTH; pop = out_valid & out_ready.
REQ-021 Push when full without pop: sample dropped, overflow set, sample_cnt unchanged.
REQ-022 Push and pop in the same cycle when full: both take effect; count stays DEPTH; no drop.
REQ-023 Push and pop in the same cycle when empty: only the push occurs, because out_valid is low.
REQ-024 Pointers wrap modulo DEPTH; FIFO order is strictly first-in first-out.
REQ-025 out_data = head entry; it is held stable while out_valid=1 and out_ready=0.
REQ-026 sample_cnt increments on each accepted push and saturates at 16383.
REQ-027 done = (sample_cnt >= N_OUT); captures continue to be accepted after done.
REQ-028 clr=1: at the next edge, count, pointers, sample_cnt, overflow, sat and valid_d are cleared; clr has priority over push and pop in that cycle.
REQ-029 Control states: EMPTY (count=0), PARTIAL, FULL (count=DEPTH).
REQ-029a EMPTY->PARTIAL on push.
REQ-029b PARTIAL->FULL on push without pop when count=DEPTH-1.
REQ-029c FULL->PARTIAL on pop without push.
REQ-029d PARTIAL->EMPTY on pop without push when count=1.
REQ-029e clr forces EMPTY from any state.

Reset
REQ-030 rstn=0 asynchronously clears valid_d, pointers, count, sample_cnt, overflow and sat.
REQ-031 During reset: out_valid=0, out_data=0, done=0.
REQ-032 Reset mid-operation discards all FIFO contents.
REQ-033 A valid_in already high when rstn deasserts is captured at the first edge (valid_d=0).

Verification
REQ-034 Rounding: din=0x00004000, SHIFT=15 -> out_data=0x0001. din=0x00003FFF -> 0x0000. din=0xFFFFC000 -> 0x0000.
REQ-035 Saturation: din=0x7FFFFFFF -> 0x7FFF with sat=1. din=0x80000000 -> 0x8000 with sat=1.
REQ-036 Edge capture: valid_in high for 5 cycles with din=0x00010000 -> exactly one entry 0x0002; sample_cnt=1.
REQ-037 Overflow: out_ready=0, 17 pulses with DEPTH=16 -> count=16, overflow=1, sample_cnt=16; draining yields the first 16 values in order.
REQ-038 Full with simultaneous push and pop: next pulse with out_ready=1 -> no drop, overflow unchanged, count stays 16.
REQ-039 Run completion and clear: 10063 pulses with out_ready=1 -> done=1 after the 10063rd push; clr then returns all outputs to their reset values.

Source files
------------

// File: rtl/fir_out_fifo.sv
// rtl/fir_out_fifo.sv - FIR result capture: round, saturate and queue 16-bit samples
// One sample is captured per rising edge of valid_in and held in a FIFO until the consumer takes it.
module fir_out_fifo #(
    parameter int SHIFT = 15,
    parameter int DEPTH = 16,
    parameter int N_OUT = 10063
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] din,
    input  logic        valid_in,
    input  logic        clr,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [13:0] sample_cnt,
    output logic        done,
    output logic        overflow,
    output logic        sat
);

    localparam int AW = $clog2(DEPTH);
    localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [32:0] RND = (SHIFT > 0) ? (33'sd1 <<< RSH) : 33'sd0;
    localparam logic [AW:0] CNT_LAST = (AW + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {ST_EMPTY, ST_PARTIAL, ST_FULL} state_t;

    state_t         state_q, state_d;
    logic           valid_q, valid_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic [13:0]    sample_cnt_q, sample_cnt_d;
    logic           overflow_q, overflow_d;
    logic           sat_q, sat_d;
    logic [15:0]    mem [DEPTH];

    logic               capture, pop, full, push, drop, clip;
    logic signed [32:0] sum_s, shf_s;
    logic [15:0]        sample;

    assign capture = valid_in & ~valid_q;
    assign full    = (state_q == ST_FULL);
    assign pop     = out_valid & out_ready;
    assign push    = capture & (~full | pop);
    assign drop    = capture & full & ~pop;

    // Round half up in 33 bits so the bias cannot wrap the accumulator.
    always_comb begin
        sum_s  = $signed({din[31], din}) + RND;
        shf_s  = sum_s >>> SHIFT;
        clip   = 1'b0;
        sample = shf_s[15:0];
        if (shf_s > 33'sd32767) begin
            sample = 16'h7FFF;
            clip   = 1'b1;
        end else if (shf_s < -33'sd32768) begin
            sample = 16'h8000;
            clip   = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_in;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        sample_cnt_d = sample_cnt_q;
        overflow_d   = overflow_q | drop;
        sat_d        = sat_q | (capture & clip);

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (sample_cnt_q != 14'h3FFF) sample_cnt_d = sample_cnt_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop) count_d = count_q + 1'b1;
        if (pop && !push) count_d = count_q - 1'b1;

        case (state_q)
            ST_EMPTY:   if (push) state_d = ST_PARTIAL;
            ST_PARTIAL: begin
                if (push && !pop && count_q == CNT_LAST) state_d = ST_FULL;
                else if (pop && !push && count_q == (AW + 1)'(1)) state_d = ST_EMPTY;
            end
            ST_FULL:    if (pop && !push) state_d = ST_PARTIAL;
            default:    state_d = ST_EMPTY;
        endcase

        if (clr) begin
            state_d      = ST_EMPTY;
            valid_d      = 1'b0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            sample_cnt_d = '0;
            overflow_d   = 1'b0;
            sat_d        = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_EMPTY;
            valid_q      <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            sample_cnt_q <= '0;
            overflow_q   <= 1'b0;
            sat_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            sample_cnt_q <= sample_cnt_d;
            overflow_q   <= overflow_d;
            sat_q        <= sat_d;
        end
    end

    // Storage is not reset; out_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push && !clr) mem[wr_ptr_q] <= sample;
    end

    assign out_valid  = (state_q != ST_EMPTY);
    assign out_data   = out_valid ? mem[rd_ptr_q] : 16'h0000;
    assign sample_cnt = sample_cnt_q;
    assign done       = ({18'd0, sample_cnt_q} >= 32'(N_OUT));
    assign overflow   = overflow_q;
    assign sat        = sat_q;

endmodule

// File: tb/tb_fir_out_fifo.sv
// tb/tb_fir_out_fifo.sv - self-checking bench for fir_out_fifo against a queue model
module tb_fir_out_fifo;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] din;
    logic        valid_in;
    logic        clr;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [13:0] sample_cnt;
    logic        done;
    logic        overflow;
    logic        sat;

    int tests = 0;
    int fails = 0;

    logic [15:0] mq[$];
    int          m_cnt;
    bit          m_vd, m_ovf, m_sat;

    fir_out_fifo dut (
        .clk(clk), .rstn(rstn), .din(din), .valid_in(valid_in), .clr(clr),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .sample_cnt(sample_cnt), .done(done), .overflow(overflow), .sat(sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_round(input logic [31:0] d, output bit clipped);
        longint v;
        v = longint'($signed(d)) + 64'sd16384;
        v = v >>> 15;
        clipped = 1'b0;
        if (v > 32767) begin clipped = 1'b1; return 16'h7FFF; end
        if (v < -32768) begin clipped = 1'b1; return 16'h8000; end
        return v[15:0];
    endfunction

    task automatic model_clear();
        mq.delete();
        m_cnt = 0; m_vd = 0; m_ovf = 0; m_sat = 0;
    endtask

    task automatic model_edge(input logic [31:0] d, input logic v, input logic r, input logic c);
        bit pop, cap, was_full, clipped;
        logic [15:0] val;
        pop = (mq.size() != 0) && r;
        cap = v && !m_vd;
        m_vd = v;
        if (c) begin
            model_clear();
            return;
        end
        was_full = (mq.size() == 16);
        if (pop) void'(mq.pop_front());
        if (cap) begin
            val = ref_round(d, clipped);
            if (clipped) m_sat = 1;
            if (was_full && !pop) m_ovf = 1;
            else begin
                mq.push_back(val);
                if (m_cnt < 16383) m_cnt++;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(mq.size() != 0));
        check({tag, ".out_data"}, 32'(out_data), (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
        check({tag, ".sample_cnt"}, 32'(sample_cnt), 32'(m_cnt));
        check({tag, ".done"}, 32'(done), 32'(m_cnt >= 10063));
        check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        check({tag, ".sat"}, 32'(sat), 32'(m_sat));
    endtask

    // Inputs are applied 1 time unit after an edge; outputs are checked 1 unit after the next edge.
    task automatic cyc(input string tag, input logic [31:0] d, input logic v, input logic r, input logic c);
        din = d; valid_in = v; out_ready = r; clr = c;
        @(posedge clk);
        model_edge(d, v, r, c);
        #1;
        check_all(tag);
    endtask

    task automatic pulse(input string tag, input logic [31:0] d, input logic r);
        cyc(tag, d, 1'b1, r, 1'b0);
        cyc(tag, d, 1'b0, r, 1'b0);
    endtask

    task automatic drain(input string tag, input int exp_n);
        int n = 0;
        for (int i = 0; i < 40 && out_valid; i++) begin
            n++;
            cyc(tag, 32'd0, 1'b0, 1'b1, 1'b0);
        end
        check({tag, ".drained"}, 32'(n), 32'(exp_n));
    endtask

    function automatic logic [31:0] rnd_din();
        logic [31:0] r = $urandom();
        if ($urandom_range(3) == 0) return r;
        return {{8{r[23]}}, r[23:0]};
    endfunction

    logic [31:0] vec_din [4] = '{32'h00003FFF, 32'hFFFFC000, 32'h7FFFFFFF, 32'h80000000};
    logic [15:0] vec_out [4] = '{16'h0000, 16'h0000, 16'h7FFF, 16'h8000};
    logic        vec_sat [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        rstn = 1'b0; din = '0; valid_in = 1'b0; clr = 1'b0; out_ready = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.out_data", 32'(out_data), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        check("reset.sample_cnt", 32'(sample_cnt), 32'd0);

        // valid_in already high as reset releases is captured at the first edge
        din = 32'h00004000; valid_in = 1'b1; rstn = 1'b1;
        cyc("first_edge", 32'h00004000, 1'b1, 1'b0, 1'b0);
        check("round_4000", 32'(out_data), 32'h0001);
        cyc("first_edge_lo", 32'h0, 1'b0, 1'b1, 1'b0);

        foreach (vec_din[i]) begin
            cyc("vec_clr", 32'h0, 1'b0, 1'b0, 1'b1);
            cyc("vec", vec_din[i], 1'b1, 1'b0, 1'b0);
            check($sformatf("vec%0d.data", i), 32'(out_data), 32'(vec_out[i]));
            check($sformatf("vec%0d.sat", i), 32'(sat), 32'(vec_sat[i]));
            cyc("vec_pop", 32'h0, 1'b0, 1'b1, 1'b0);
        end

        cyc("edge_clr", 32'h0, 1'b0, 1'b0, 1'b1);
        repeat (5) cyc("edge_hi", 32'h00010000, 1'b1, 1'b0, 1'b0);
        cyc("edge_lo", 32'h00010000, 1'b0, 1'b0, 1'b0);
        check("edge.sample_cnt", 32'(sample_cnt), 32'd1);
        check("edge.data", 32'(out_data), 32'h0002);
        drain("edge_drain", 1);

        cyc("ovf_clr", 32'h0, 1'b0, 1'b0, 1'b1);
        repeat (17) pulse("ovf_fill", rnd_din(), 1'b0);
        check("ovf.overflow", 32'(overflow), 32'd1);
        check("ovf.sample_cnt", 32'(sample_cnt), 32'd16);
        drain("ovf_drain", 16);

        cyc("pp_clr", 32'h0, 1'b0, 1'b0, 1'b1);
        repeat (16) pulse("pp_fill", rnd_din(), 1'b0);
        cyc("pp_both", rnd_din(), 1'b1, 1'b1, 1'b0);
        check("pp.overflow", 32'(overflow), 32'd0);
        check("pp.sample_cnt", 32'(sample_cnt), 32'd17);
        cyc("pp_lo", 32'h0, 1'b0, 1'b0, 1'b0);
        drain("pp_drain", 16);

        // reset in the middle of operation discards stored samples
        repeat (3) pulse("mid_fill", rnd_din(), 1'b0);
        rstn = 1'b0; valid_in = 1'b0;
        #1;
        model_clear();
        check("midrst.out_valid", 32'(out_valid), 32'd0);
        check("midrst.out_data", 32'(out_data), 32'd0);
        check("midrst.sample_cnt", 32'(sample_cnt), 32'd0);
        check("midrst.overflow", 32'(overflow), 32'd0);
        rstn = 1'b1;
        cyc("midrst_after", 32'h0, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 400; i++)
            cyc("rand", rnd_din(), 1'($urandom_range(1)), 1'($urandom_range(3) != 0),
                1'($urandom_range(60) == 0));

        cyc("run_clr", 32'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10062; i++) pulse("run", rnd_din(), 1'b1);
        check("run.done_before", 32'(done), 32'd0);
        cyc("run_last", rnd_din(), 1'b1, 1'b1, 1'b0);
        check("run.done", 32'(done), 32'd1);
        check("run.sample_cnt", 32'(sample_cnt), 32'd10063);
        cyc("run_lo", 32'h0, 1'b0, 1'b1, 1'b0);
        pulse("run_after", rnd_din(), 1'b0);
        cyc("run_final_clr", 32'h0, 1'b0, 1'b0, 1'b1);
        check("clr.out_valid", 32'(out_valid), 32'd0);
        check("clr.out_data", 32'(out_data), 32'd0);
        check("clr.done", 32'(done), 32'd0);
        check("clr.sample_cnt", 32'(sample_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
